// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data memory arbiter: access sizes, port indices,
// sequencer states and the read-data extension helper.
package mem_arb_pkg;

  localparam logic [1:0] SIZE_HALF   = 2'b00;
  localparam logic [1:0] SIZE_BYTE_Z = 2'b01;
  localparam logic [1:0] SIZE_BYTE_S = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    WAIT,
    DONE
  } state_t;

  // fin is the last byte returned by memory; lo is the earlier low byte of a halfword.
  function automatic logic [15:0] extend_rd(input logic [1:0] size,
                                            input logic [7:0] fin,
                                            input logic [7:0] lo);
    logic [15:0] r;
    case (size)
      SIZE_HALF:   r = {fin, lo};
      SIZE_BYTE_S: r = {{8{fin[7]}}, fin};
      default:     r = {8'h00, fin};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request grant picker. With MEM_ARB_ROUND_ROBIN_EN defined it alternates
// on ties using a last-grant register; otherwise port 0 always wins ties.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  // Resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= PORT1;
    end else if (accept && valid) begin
      last_gnt <= idx;
    end
  end

  always_comb begin
    idx = PORT0;
    if (req[0] && req[1]) begin
      idx = ~last_gnt;
    end else if (req[1]) begin
      idx = PORT1;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, accept};

  assign idx = req[0] ? PORT0 : req[1];
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the byte-wide data memory between the pipeline (port 0) and the
// loader (port 1); tie policy selected by MEM_ARB_ROUND_ROBIN_EN.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch command on exit
// ACC_LO | strobe memory at the latched address (low byte)
// ACC_HI | strobe address+1 (high byte); capture low read byte
// WAIT   | capture final read byte into the granted port's rdata
// DONE   | one-cycle done pulse to the granted port
module data_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  output logic              done0,
  output logic              done1,
  output logic [15:0]       rdata0,
  output logic [15:0]       rdata1,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRdEnable,
  output logic              memWrEnable,
  output logic [7:0]        memWrData,
  input  logic [7:0]        memRdData,
  output logic              busy
);

  state_t state, state_nxt;

  logic              arb_valid;
  logic              arb_idx;
  logic              accept;

  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;

  logic              gnt_port;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_wdata_hi;
  logic [7:0]        lo_byte;
  logic [15:0]       rd_word;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .accept (accept),
    .valid  (arb_valid),
    .idx    (arb_idx)
  );

  assign accept    = (state == IDLE) && arb_valid;
  assign sel_we    = (arb_idx == PORT1) ? we1    : we0;
  assign sel_size  = (arb_idx == PORT1) ? size1  : size0;
  assign sel_addr  = (arb_idx == PORT1) ? addr1  : addr0;
  assign sel_wdata = (arb_idx == PORT1) ? wdata1 : wdata0;
  assign busy      = (state != IDLE);
  assign rd_word   = extend_rd(lat_size, memRdData, lo_byte);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = ACC_LO;
      ACC_LO: begin
        if (lat_size == SIZE_HALF) state_nxt = ACC_HI;
        else if (!lat_we)          state_nxt = WAIT;
        else                       state_nxt = DONE;
      end
      ACC_HI:  state_nxt = lat_we ? DONE : WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes and done are decoded from the next state so they come
  // straight out of flops during the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memAddr     <= '0;
      memRdEnable <= 1'b0;
      memWrEnable <= 1'b0;
      memWrData   <= 8'h00;
      done0       <= 1'b0;
      done1       <= 1'b0;
    end else begin
      memRdEnable <= 1'b0;
      memWrEnable <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      case (state_nxt)
        ACC_LO: begin
          memAddr     <= sel_addr;
          memRdEnable <= ~sel_we;
          memWrEnable <= sel_we;
          memWrData   <= sel_wdata[7:0];
        end
        ACC_HI: begin
          memAddr     <= lat_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          memRdEnable <= ~lat_we;
          memWrEnable <= lat_we;
          memWrData   <= lat_wdata_hi;
        end
        DONE: begin
          done0 <= (gnt_port == PORT0);
          done1 <= (gnt_port == PORT1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_port     <= PORT0;
      lat_we       <= 1'b0;
      lat_size     <= SIZE_HALF;
      lat_addr     <= '0;
      lat_wdata_hi <= 8'h00;
      lo_byte      <= 8'h00;
      rdata0       <= 16'h0000;
      rdata1       <= 16'h0000;
    end else begin
      if (accept) begin
        gnt_port     <= arb_idx;
        lat_we       <= sel_we;
        lat_size     <= (sel_size == 2'b11) ? SIZE_BYTE_Z : sel_size;
        lat_addr     <= sel_addr;
        lat_wdata_hi <= sel_wdata[15:8];
      end
      if (state == ACC_HI && !lat_we) begin
        lo_byte <= memRdData;
      end
      if (state == WAIT) begin
        if (gnt_port == PORT0) rdata0 <= rd_word;
        else                   rdata1 <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: transaction-level model plus
// directed scenarios; tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_data_memory_arbiter;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    bit          port;
    logic [15:0] d;
    int          c;
  } log_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [1:0]  size  [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];

  logic        done0, done1, busy;
  logic [15:0] rdata0, rdata1;
  logic [15:0] memAddr;
  logic        memRdEnable, memWrEnable;
  logic [7:0]  memWrData;
  logic [7:0]  memRdData = 8'h00;
  logic [1:0]  dn;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  cmd_t cq [2][$];
  log_t log_q [$];
  int   start_cyc [2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit          pend_valid = 1'b0;
  bit          pend_port, pend_read;
  int          pend_grant, pend_done;
  logic [15:0] pend_data;
  logic [15:0] m_rd [2];
  bit          last_gnt = 1'b1;
  bit          exp_ord [4];

  data_memory_arbiter #(.ADDR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req[0]),
    .req1        (req[1]),
    .we0         (we[0]),
    .we1         (we[1]),
    .size0       (size[0]),
    .size1       (size[1]),
    .addr0       (addr[0]),
    .addr1       (addr[1]),
    .wdata0      (wdata[0]),
    .wdata1      (wdata[1]),
    .done0       (done0),
    .done1       (done1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .memAddr     (memAddr),
    .memRdEnable (memRdEnable),
    .memWrEnable (memWrEnable),
    .memWrData   (memWrData),
    .memRdData   (memRdData),
    .busy        (busy)
  );

  assign dn = {done1, done0};

  always #5 clk = ~clk;

  // Byte-wide memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (memRdEnable) memRdData <= mem[memAddr];
    if (memWrEnable) mem[memAddr] = memWrData;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply(input int p, input cmd_t c);
    we[p]    = c.we;
    size[p]  = c.size;
    addr[p]  = c.addr;
    wdata[p] = c.wdata;
  endtask

  // Requesters: hold req until done, then issue the next queued command or drop.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        req[p] = 1'b0;
        cq[p].delete();
      end else if (req[p] && dn[p]) begin
        if (cq[p].size() > 0) begin
          apply(p, cq[p].pop_front());
          start_cyc[p] = cyc + 1;
        end else begin
          req[p] = 1'b0;
        end
      end else if (!req[p] && cq[p].size() > 0) begin
        apply(p, cq[p].pop_front());
        req[p] = 1'b1;
        start_cyc[p] = cyc;
      end
    end
  end

  task automatic model_clear();
    pend_valid = 1'b0;
    m_rd[0]    = 16'h0000;
    m_rd[1]    = 16'h0000;
    last_gnt   = 1'b1;
  endtask

  // Transaction model: one access at a time, latency from size and direction.
  task automatic model_grant(input int p);
    logic [15:0] a, a1;
    logic [1:0]  sz;
    a  = addr[p];
    a1 = a + 16'd1;
    sz = size[p];
    pend_port  = p[0];
    pend_read  = !we[p];
    pend_grant = cyc;
    pend_done  = cyc + 2 + ((sz == 2'b00) ? 1 : 0) + (we[p] ? 0 : 1);
    if (we[p]) begin
      ref_mem[a] = wdata[p][7:0];
      if (sz == 2'b00) ref_mem[a1] = wdata[p][15:8];
    end else if (sz == 2'b00) begin
      pend_data = {ref_mem[a1], ref_mem[a]};
    end else if (sz == 2'b10) begin
      pend_data = {{8{ref_mem[a][7]}}, ref_mem[a]};
    end else begin
      pend_data = {8'h00, ref_mem[a]};
    end
    pend_valid = 1'b1;
  endtask

  always @(posedge reset) model_clear();

  always @(posedge clk) begin
    int p;
    if (reset) begin
      model_clear();
    end else if (!pend_valid && (req[0] || req[1])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (req[0] && req[1]) p = last_gnt ? 0 : 1;
      else                  p = req[0] ? 0 : 1;
`else
      p = req[0] ? 0 : 1;
`endif
      last_gnt = p[0];
      model_grant(p);
    end else if (pend_valid && cyc == pend_done) begin
      pend_valid = 1'b0;
    end
    cyc++;
    if (!reset && pend_valid && pend_read && cyc == pend_done) m_rd[pend_port] = pend_data;
  end

  always @(negedge clk) begin
    bit e0, e1, eb;
    e0 = !reset && pend_valid && cyc == pend_done && !pend_port;
    e1 = !reset && pend_valid && cyc == pend_done && pend_port;
    eb = !reset && pend_valid && cyc > pend_grant && cyc <= pend_done;
    chk("done0", done0, e0);
    chk("done1", done1, e1);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
    chk("busy", busy, eb);
    chk("strobe_both", memRdEnable & memWrEnable, 0);
    chk("strobe_outside_txn", (memRdEnable | memWrEnable) & ~eb, 0);
    if (done0) log_q.push_back('{1'b0, rdata0, cyc});
    if (done1) log_q.push_back('{1'b1, rdata1, cyc});
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk);
    while ((cq[0].size() != 0 || cq[1].size() != 0 || req[0] || req[1] || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required idle", busy, n);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic single(input int p, input logic w, input logic [1:0] sz, input logic [15:0] a,
                        input logic [15:0] wd, input int lat, input logic [15:0] rd, input string nm);
    int n0;
    n0 = log_q.size();
    @(posedge clk);
    cq[p].push_back('{w, sz, a, wd});
    wait_idle();
    chk({nm, "_count"}, log_q.size(), n0 + 1);
    if (log_q.size() == n0 + 1) begin
      chk({nm, "_port"}, log_q[n0].port, p);
      chk({nm, "_latency"}, log_q[n0].c - start_cyc[p], lat);
      if (!w) chk({nm, "_rdata"}, log_q[n0].d, rd);
    end
  endtask

  initial begin
    int n0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; size[p] = 2'b00; addr[p] = 16'h0000; wdata[p] = 16'h0000;
      start_cyc[p] = 0;
    end
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWrData", memWrData, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    single(0, 1'b1, 2'b00, 16'h0010, 16'hA55A, 3, 16'h0000, "hw_wr");
    chk("mem_10", mem[16'h0010], 8'h5A);
    chk("mem_11", mem[16'h0011], 8'hA5);
    single(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 4, 16'hA55A, "hw_rd");

    mem[16'h0020] = 8'h80;
    ref_mem[16'h0020] = 8'h80;
    single(0, 1'b0, 2'b01, 16'h0020, 16'h0000, 3, 16'h0080, "rd_byte_z");
    single(1, 1'b0, 2'b10, 16'h0020, 16'h0000, 3, 16'hFF80, "rd_byte_s");
    single(1, 1'b0, 2'b11, 16'h0020, 16'h0000, 3, 16'h0080, "rd_byte_11");

    single(1, 1'b1, 2'b01, 16'h0030, 16'h9977, 2, 16'h0000, "byte_wr");
    chk("mem_30", mem[16'h0030], 8'h77);
    chk("mem_31", mem[16'h0031], 8'h00);

    single(0, 1'b1, 2'b00, 16'hFFFF, 16'h1234, 3, 16'h0000, "hw_wr_wrap");
    chk("mem_ffff", mem[16'hFFFF], 8'h34);
    chk("mem_0000", mem[16'h0000], 8'h12);
    single(1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 4, 16'h1234, "hw_rd_wrap");

    // Both ports held for four transactions each; last grant was port 1.
    n0 = log_q.size();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      cq[0].push_back('{1'b1, 2'b01, 16'h0100 + 16'(i), 16'h00A0 + 16'(i)});
      cq[1].push_back('{1'b1, 2'b01, 16'h0200 + 16'(i), 16'h00B0 + 16'(i)});
    end
    wait_idle();
    chk("arb_count", log_q.size(), n0 + 8);
    if (log_q.size() == n0 + 8) begin
      for (int i = 0; i < 4; i++) chk($sformatf("arb_order_%0d", i), log_q[n0 + i].port, exp_ord[i]);
    end
    chk("mem_103", mem[16'h0103], 8'hA3);
    chk("mem_203", mem[16'h0203], 8'hB3);

    // Reset during the high-byte write.
    n0 = log_q.size();
    @(posedge clk);
    cq[0].push_back('{1'b1, 2'b00, 16'h0040, 16'hBEEF});
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("acchi_wr_en", memWrEnable, 1);
    chk("acchi_addr", memAddr, 16'h0041);
    chk("acchi_wdata", memWrData, 8'hBE);
    #1 reset = 1'b1;
    #1;
    chk("midrst_wr_en", memWrEnable, 0);
    chk("midrst_addr", memAddr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wdata", memWrData, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[16'h0041] = 8'h00;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", log_q.size(), n0);
    chk("mem_40", mem[16'h0040], 8'hEF);
    chk("mem_41", mem[16'h0041], 8'h00);
    single(0, 1'b0, 2'b00, 16'h0040, 16'h0000, 4, 16'h00EF, "rd_after_rst");

    // Port 1 waits behind port 0, whose address line changes mid-access.
    n0 = log_q.size();
    @(posedge clk);
    cq[0].push_back('{1'b1, 2'b00, 16'h0050, 16'h3C5A});
    @(posedge clk);
    cq[1].push_back('{1'b0, 2'b00, 16'h0050, 16'h0000});
    @(negedge clk);
    addr[0]  = 16'h0060;
    wdata[0] = 16'hFFFF;
    wait_idle();
    chk("latch_count", log_q.size(), n0 + 2);
    if (log_q.size() == n0 + 2) begin
      chk("latch_first_port", log_q[n0].port, 0);
      chk("latch_second_port", log_q[n0 + 1].port, 1);
      chk("latch_second_rdata", log_q[n0 + 1].d, 16'h3C5A);
    end
    chk("mem_50", mem[16'h0050], 8'h5A);
    chk("mem_51", mem[16'h0051], 8'h3C);
    chk("mem_60", mem[16'h0060], 8'h00);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Sequencing controller and two-port arbiter in front of the byte-wide, single-port data memory. It shares the memory between the pipeline MEM stage (port 0) and the program/debug loader (port 1). Each granted 16-bit access is split into little-endian byte cycles, and read data is zero- or sign-extended. It returns a one-cycle completion pulse per transaction.

## Interface
Parameters:
- ADDR_W, 16, byte-address width for requesters and memory.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- req0 / req1  in  1  request from port 0 (pipeline) / port 1 (loader); level-held until done.
- we0 / we1  in  1  1 = write, 0 = read.
- size0 / size1  in  2  00 halfword, 01 byte zero-extend, 10 byte sign-extend, 11 treated as 01.
- addr0 / addr1  in  ADDR_W  byte address; halfword low byte at addr, high byte at addr+1.
- wdata0 / wdata1  in  16  write data; byte writes use [7:0].
- done0 / done1  out  1  registered one-cycle completion pulse; reset 0.
- rdata0 / rdata1  out  16  registered read result, valid while done is high, held until next read completes; reset 0.
- memAddr  out  ADDR_W  memory byte address; reset 0.
- memRdEnable / memWrEnable  out  1  memory strobes, never both high; reset 0.
- memWrData  out  8  byte to write; reset 0.
- memRdData  in  8  memory read byte, valid the cycle after memRdEnable.
- busy  out  1  high in every state except IDLE; reset 0.

## Operation
- Command (we, size, addr, wdata) of the granted port is latched on the grant edge. Later changes on the input lines are ignored until DONE.
- FSM states:
  - IDLE: if any req, grant, latch, and go to ACC_LO.
  - ACC_LO: strobe at the latched address. Next state is ACC_HI if halfword, else WAIT if read, else DONE.
  - ACC_HI: strobe at address+1. For a read, capture the low byte from memRdData. Next state is WAIT if read, else DONE.
  - WAIT: capture the final byte into rdata of the granted port, then go to DONE.
  - DONE: done of the granted port is high for this cycle only, then go to IDLE.
- Read result:
  - halfword = {hi, lo}.
  - size 01/11 = {8'h00, b}.
  - size 10 = {{8{b[7]}}, b}.
- Address+1 wraps modulo 2^ADDR_W; 0xFFFF+1 = 0x0000.
- Requester drops req on the edge ending its done cycle. req still high when IDLE samples it is a new transaction (back-to-back is legal).
- The non-granted requester waits with req held; it is never lost.
- Reset mid-transaction: return to IDLE immediately and abandon the access, with no done. A halfword write may leave only its low byte written.

## Timing
- Request sampled in IDLE at cycle T.
- done asserts at:
  - byte write: T+2
  - halfword write: T+3
  - byte read: T+3
  - halfword read: T+4
- Next grant is at earliest the cycle after DONE, which is IDLE.
- memRdEnable/memWrEnable are high only in ACC_LO/ACC_HI, and are registered so they are glitch-free.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous req0 and req1 in IDLE, grant the port not granted last.
  - Last-grant register resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties. The loader can starve while the pipeline streams; this is acceptable for normal run mode.
- A lone requester is granted immediately in both builds.

## Structure
- Package mem_arb_pkg:
  - size encoding constants SIZE_HALF/SIZE_BYTE_Z/SIZE_BYTE_S.
  - state enum IDLE/ACC_LO/ACC_HI/WAIT/DONE.
  - port index constants.
- Sub-module rr_arbiter2: two-request grant picker holding the last-grant register. Under the macro it rotates; otherwise it is a fixed-priority encoder.
- Top holds the FSM, command latch, byte assembly and extension.

## Test plan
- Port 0 halfword write 0xA55A to 0x0010, then halfword read of 0x0010 -> mem[0x10]=0x5A, mem[0x11]=0xA5; done0 at T+3 for the write; rdata0=0xA55A with done0 at T+4 for the read.
- mem[0x20]=0x80; byte reads size 01 and size 10 -> rdata 0x0080 and 0xFF80, done at T+3; size 11 -> 0x0080.
- Halfword write 0x1234 at 0xFFFF -> mem[0xFFFF]=0x34, mem[0x0000]=0x12.
- req0 and req1 both held for 4 transactions:
  - with MEM_ARB_ROUND_ROBIN_EN -> grants 0,1,0,1.
  - without it -> grants 0,0,0,0 while req0 stays high.
- Assert reset during ACC_HI of a halfword write -> outputs 0 that cycle, no done, only the low byte written, next request serviced normally.
- req1 held while port 0 is active; change addr0 mid-transaction -> port 0 completes with its latched address, then port 1 is served next with its held command.
